// File: rtl/commit_stage_nport_if.sv
// Shared commit-stage types plus the scoreboard <-> commit-stage bundle.
// The scoreboard drives head entries and the commit stage returns acks and regfile writes.
package commit_stage_nport_pkg;
  localparam int unsigned XLEN = 64;

  typedef enum logic [3:0] {
    FU_NONE, FU_LOAD, FU_STORE, FU_ALU, FU_CTRL_FLOW, FU_MULT,
    FU_CSR, FU_FPU, FU_FPU_VEC, FU_ACCEL
  } fu_t;

  typedef enum logic [4:0] {
    OP_ADD, OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_FENCE, OP_FENCE_I, OP_SFENCE_VMA,
    OP_AMO_LR, OP_AMO_SC, OP_AMO_SWAP, OP_AMO_ADD, OP_FADD
  } op_t;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic            valid;
    fu_t             fu;
    op_t             op;
    logic [4:0]      rd;
    logic            rd_fpr;
    logic            vfp;
    logic [XLEN-1:0] result;
    exception_t      ex;
  } scoreboard_entry_t;

  typedef struct packed {
    logic            ack;
    logic [XLEN-1:0] result;
  } amo_resp_t;

  function automatic logic is_amo(op_t op);
    return op inside {OP_AMO_LR, OP_AMO_SC, OP_AMO_SWAP, OP_AMO_ADD};
  endfunction

  function automatic logic is_fence(op_t op);
    return op inside {OP_FENCE, OP_FENCE_I, OP_SFENCE_VMA};
  endfunction
endpackage

interface commit_stage_nport_if
  import commit_stage_nport_pkg::*;
#(
  parameter int unsigned NrCommitPorts = 2
);
  scoreboard_entry_t [NrCommitPorts-1:0]           commit_instr_i;
  logic              [NrCommitPorts-1:0]           commit_ack_o;
  logic              [NrCommitPorts-1:0][4:0]      waddr_o;
  logic              [NrCommitPorts-1:0][XLEN-1:0] wdata_o;
  logic              [NrCommitPorts-1:0]           we_gpr_o;
  logic              [NrCommitPorts-1:0]           we_fpr_o;

  // Scoreboard side
  modport master (
    output commit_instr_i,
    input  commit_ack_o, waddr_o, wdata_o, we_gpr_o, we_fpr_o
  );

  // Commit-stage side
  modport slave (
    input  commit_instr_i,
    output commit_ack_o, waddr_o, wdata_o, we_gpr_o, we_fpr_o
  );
endinterface

// File: rtl/commit_stage_nport.sv
// N-port in-order commit stage: retires the longest eligible head prefix per cycle,
// sequences fence drains and AMO completion, and watches for a stuck head.
module commit_stage_nport
  import commit_stage_nport_pkg::*;
#(
  parameter int unsigned NrCommitPorts     = 2,
  parameter int unsigned MaxStoresPerCycle = 1,
  parameter int unsigned StallThreshold    = 1024,
  parameter bit          FpPresent         = 1'b1,
  parameter bit          RVA               = 1'b1,
  localparam int unsigned CreditW = $clog2(MaxStoresPerCycle + 1),
  localparam int unsigned RetireW = $clog2(NrCommitPorts + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 halt_i,
  input  logic                 flush_dcache_i,
  input  logic                 single_step_i,
  commit_stage_nport_if.slave  cif,
  input  logic [CreditW-1:0]   lsu_credit_i,
  output logic [NrCommitPorts-1:0] commit_lsu_o,
  input  logic                 no_st_pending_i,
  input  amo_resp_t            amo_resp_i,
  output logic                 amo_valid_commit_o,
  output op_t                  csr_op_o,
  output logic [XLEN-1:0]      csr_wdata_o,
  input  logic [XLEN-1:0]      csr_rdata_i,
  input  exception_t           csr_exception_i,
  output logic                 csr_write_fflags_o,
  output logic                 commit_csr_o,
  output logic                 fence_o,
  output logic                 fence_i_o,
  output logic                 sfence_vma_o,
  output logic                 flush_commit_o,
  output exception_t           exception_o,
  output logic                 dirty_fp_state_o,
  output logic [RetireW-1:0]   retire_cnt_o,
  output logic                 commit_stall_o
);

  localparam int unsigned CntW = $clog2(StallThreshold + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_AMO_WAIT} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     stall_cnt_q, stall_cnt_d;
  logic                stall_q, stall_d;
  logic [RetireW-1:0]  retire_cnt_q, retire_cnt_d;

  scoreboard_entry_t   head;
  logic                head_fence, head_csr, head_amo, head_drain;
  logic                elig0, later_ok, pulse, amo_done, blocked;
  logic [NrCommitPorts-1:0] ack, plain_st, fu_ok;
  logic [4:0]          fflags_acc;
  int unsigned         st_lim, st_cnt;

  assign head       = cif.commit_instr_i[0];
  assign head_fence = head.fu == FU_CSR && is_fence(head.op);
  assign head_csr   = head.fu == FU_CSR && !is_fence(head.op);
  assign head_amo   = head.fu == FU_STORE && is_amo(head.op);
  // A D$ flush request turns any non-store head into a FENCE_I-style drain
  assign head_drain = head_fence || (flush_dcache_i && head.fu != FU_STORE);

  // Per-port classification used by the prefix and store-credit passes
  always_comb begin
    plain_st = '0;
    fu_ok    = '0;
    for (int i = 0; i < NrCommitPorts; i++) begin
      plain_st[i] = cif.commit_instr_i[i].fu == FU_STORE && !is_amo(cif.commit_instr_i[i].op);
      fu_ok[i]    = plain_st[i] ||
                    (cif.commit_instr_i[i].fu inside {FU_ALU, FU_LOAD, FU_CTRL_FLOW, FU_MULT}) ||
                    (FpPresent && (cif.commit_instr_i[i].fu inside {FU_FPU, FU_FPU_VEC}));
    end
  end

  always_comb begin
    state_d            = state_q;
    ack                = '0;
    pulse              = 1'b0;
    amo_done           = 1'b0;
    amo_valid_commit_o = 1'b0;
    csr_op_o           = OP_ADD;
    csr_wdata_o        = '0;
    commit_csr_o       = 1'b0;
    csr_write_fflags_o = 1'b0;
    fence_o            = 1'b0;
    fence_i_o          = 1'b0;
    sfence_vma_o       = 1'b0;
    flush_commit_o     = 1'b0;
    exception_o        = '0;
    dirty_fp_state_o   = 1'b0;
    commit_lsu_o       = '0;
    cif.commit_ack_o   = '0;
    cif.waddr_o        = '0;
    cif.wdata_o        = '0;
    cif.we_gpr_o       = '0;
    cif.we_fpr_o       = '0;
    fflags_acc         = '0;
    st_cnt             = 0;
    blocked            = 1'b0;
    st_lim             = (MaxStoresPerCycle < 32'(lsu_credit_i)) ? MaxStoresPerCycle
                                                                 : 32'(lsu_credit_i);

    // Head exception wins over a CSR-reported one; CSR traps reuse the head's tval
    if (head.valid && state_q == S_IDLE) begin
      if (head.ex.valid) begin
        exception_o = head.ex;
      end else if (head_csr && !head_drain && csr_exception_i.valid) begin
        exception_o      = csr_exception_i;
        exception_o.tval = head.ex.tval;
      end
    end
    if (halt_i) exception_o.valid = 1'b0;

    elig0 = head.valid && !head.ex.valid &&
            ((!halt_i && state_q == S_IDLE) || state_q == S_AMO_WAIT);

    unique case (state_q)
      S_IDLE: begin
        if (elig0) begin
          if (head_drain) begin
            if (no_st_pending_i) begin
              ack[0] = 1'b1;
              pulse  = 1'b1;
            end else begin
              state_d = S_DRAIN;
            end
          end else if (head_amo) begin
            if (RVA) begin
              amo_valid_commit_o = 1'b1;
              if (amo_resp_i.ack) begin
                ack[0]   = 1'b1;
                amo_done = 1'b1;
              end else begin
                state_d = S_AMO_WAIT;
              end
            end
          end else if (head_csr) begin
            csr_op_o    = head.op;
            csr_wdata_o = head.result;
            if (!csr_exception_i.valid) begin
              ack[0]       = 1'b1;
              commit_csr_o = 1'b1;
            end
          end else begin
            ack[0] = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (halt_i || !head.valid) begin
          state_d = S_IDLE;
        end else if (no_st_pending_i) begin
          ack[0]  = 1'b1;
          pulse   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_AMO_WAIT: begin
        if (!elig0) begin
          state_d = S_IDLE;
        end else begin
          amo_valid_commit_o = 1'b1;
          if (amo_resp_i.ack) begin
            ack[0]   = 1'b1;
            amo_done = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pulse) begin
      if (head_fence && head.op == OP_FENCE)           fence_o      = 1'b1;
      else if (head_fence && head.op == OP_SFENCE_VMA) sfence_vma_o = 1'b1;
      else                                             fence_i_o    = 1'b1;
    end
    flush_commit_o = amo_done;

    // Younger ports extend the prefix only behind a plain head with no side conditions
    later_ok = !halt_i && !flush_dcache_i && !single_step_i && !exception_o.valid &&
               !head_csr && !head_fence && !head_amo && state_q == S_IDLE;
    for (int i = 1; i < NrCommitPorts; i++) begin
      if (ack[i-1] && later_ok && cif.commit_instr_i[i].valid &&
          !cif.commit_instr_i[i].ex.valid && fu_ok[i])
        ack[i] = 1'b1;
    end

    // The first store beyond the credit limit truncates the prefix
    for (int i = 0; i < NrCommitPorts; i++) begin
      if (blocked || !ack[i]) begin
        ack[i]  = 1'b0;
        blocked = 1'b1;
      end else if (plain_st[i]) begin
        if (st_cnt < st_lim) st_cnt = st_cnt + 1;
        else begin
          ack[i]  = 1'b0;
          blocked = 1'b1;
        end
      end
    end

    if (head.valid) begin
      for (int i = 0; i < NrCommitPorts; i++) begin
        cif.waddr_o[i]  = cif.commit_instr_i[i].rd;
        cif.wdata_o[i]  = cif.commit_instr_i[i].result;
        commit_lsu_o[i] = ack[i] && plain_st[i];
        if (ack[i] && cif.commit_instr_i[i].fu != FU_STORE &&
            !(cif.commit_instr_i[i].fu == FU_CSR && is_fence(cif.commit_instr_i[i].op))) begin
          if (FpPresent && cif.commit_instr_i[i].rd_fpr) cif.we_fpr_o[i] = 1'b1;
          else                                            cif.we_gpr_o[i] = 1'b1;
        end
        if (ack[i] && FpPresent && (cif.commit_instr_i[i].fu inside {FU_FPU, FU_FPU_VEC})) begin
          csr_write_fflags_o = 1'b1;
          fflags_acc         = fflags_acc | cif.commit_instr_i[i].ex.cause[4:0];
        end
        if (ack[i] && FpPresent &&
            ((cif.commit_instr_i[i].fu inside {FU_FPU, FU_FPU_VEC}) || cif.commit_instr_i[i].rd_fpr ||
             (cif.commit_instr_i[i].fu == FU_ACCEL && cif.commit_instr_i[i].vfp)))
          dirty_fp_state_o = 1'b1;
      end
      if (commit_csr_o) cif.wdata_o[0] = csr_rdata_i;
      if (amo_done) begin
        cif.we_gpr_o[0] = 1'b1;
        cif.wdata_o[0]  = amo_resp_i.result;
      end
      if (csr_write_fflags_o) csr_wdata_o = XLEN'(fflags_acc);
    end
    cif.commit_ack_o = ack;

    // Saturating head-stall counter and retire count for the next cycle
    if (head.valid && !ack[0])
      stall_cnt_d = (stall_cnt_q == CntW'(StallThreshold)) ? stall_cnt_q : stall_cnt_q + CntW'(1);
    else
      stall_cnt_d = '0;
    stall_d = stall_cnt_d == CntW'(StallThreshold);

    retire_cnt_d = '0;
    for (int i = 0; i < NrCommitPorts; i++)
      retire_cnt_d = retire_cnt_d + RetireW'(ack[i]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      stall_cnt_q  <= '0;
      stall_q      <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
      stall_q      <= stall_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt_o   = retire_cnt_q;
  assign commit_stall_o = stall_q;

endmodule

// File: tb/tb_commit_stage_nport.sv
// Scoreboard-style bench for commit_stage_nport: expectations are queued as stimulus is applied.
module tb_commit_stage_nport;
  import commit_stage_nport_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned MS = 2;
  localparam int unsigned ST = 4;
  localparam int unsigned CW = $clog2(MS + 1);
  localparam int unsigned RW = $clog2(NP + 1);

  logic clk = 1'b0;
  logic rst_n;
  logic halt, flush_dcache, single_step, no_st_pending;
  logic [CW-1:0] lsu_credit;
  logic [NP-1:0] commit_lsu;
  amo_resp_t amo_resp;
  logic amo_valid;
  op_t csr_op;
  logic [XLEN-1:0] csr_wdata, csr_rdata;
  exception_t csr_exc, exc;
  logic fflags_we, commit_csr, fence, fence_i, sfence, flush_commit, dirty_fp, stall;
  logic [RW-1:0] retire_cnt;

  always #5 clk = ~clk;

  commit_stage_nport_if #(.NrCommitPorts(NP)) cif ();

  commit_stage_nport #(
    .NrCommitPorts(NP), .MaxStoresPerCycle(MS), .StallThreshold(ST), .FpPresent(1'b1), .RVA(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .halt_i(halt), .flush_dcache_i(flush_dcache),
    .single_step_i(single_step), .cif(cif), .lsu_credit_i(lsu_credit), .commit_lsu_o(commit_lsu),
    .no_st_pending_i(no_st_pending), .amo_resp_i(amo_resp), .amo_valid_commit_o(amo_valid),
    .csr_op_o(csr_op), .csr_wdata_o(csr_wdata), .csr_rdata_i(csr_rdata),
    .csr_exception_i(csr_exc), .csr_write_fflags_o(fflags_we), .commit_csr_o(commit_csr),
    .fence_o(fence), .fence_i_o(fence_i), .sfence_vma_o(sfence), .flush_commit_o(flush_commit),
    .exception_o(exc), .dirty_fp_state_o(dirty_fp), .retire_cnt_o(retire_cnt),
    .commit_stall_o(stall)
  );

  string       name_q[$];
  logic [63:0] val_q[$];
  string       nm;
  logic [63:0] ev;
  int checks = 0;
  int errors = 0;

  function automatic scoreboard_entry_t ent(fu_t fu, op_t op, logic [4:0] rd, logic [63:0] res);
    ent = '0;
    ent.valid = 1'b1; ent.fu = fu; ent.op = op; ent.rd = rd; ent.result = res;
  endfunction

  task automatic expect_val(string n, logic [63:0] v);
    name_q.push_back(n); val_q.push_back(v);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_idle();
    halt = 0; flush_dcache = 0; single_step = 0; no_st_pending = 1; lsu_credit = CW'(2);
    amo_resp = '0; csr_rdata = '0; csr_exc = '0; cif.commit_instr_i = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; set_idle();
    repeat (2) @(posedge clk);
    expect_val("rst_ack", 64'h0); expect_val("rst_retire", 64'h0); expect_val("rst_stall", 64'h0);
    @(negedge clk);
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(cif.commit_ack_o) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, cif.commit_ack_o, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(retire_cnt) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, retire_cnt, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(stall) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, stall, ev); end
    step(); rst_n = 1'b1;
  endtask

  task automatic test_alu4();
    step(); set_idle();
    for (int i = 0; i < NP; i++) cif.commit_instr_i[i] = ent(FU_ALU, OP_ADD, 5'(i + 1), 64'h100 + 64'(i));
    expect_val("alu4_ack", 64'hf); expect_val("alu4_we_gpr", 64'hf);
    expect_val("alu4_waddr3", 64'h4); expect_val("alu4_wdata2", 64'h102);
    @(negedge clk);
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(cif.commit_ack_o) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, cif.commit_ack_o, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(cif.we_gpr_o) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, cif.we_gpr_o, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(cif.waddr_o[3]) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, cif.waddr_o[3], ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (cif.wdata_o[2] !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, cif.wdata_o[2], ev); end
    step(); set_idle();
    expect_val("alu4_retire_cnt", 64'h4);
    @(negedge clk);
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(retire_cnt) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, retire_cnt, ev); end
  endtask

  task automatic test_store_credit();
    logic [NP-1:0] exp_ack [3];
    logic [NP-1:0] exp_lsu [3];
    exp_ack = '{4'b0001, 4'b0111, 4'b0000};
    exp_lsu = '{4'b0001, 4'b0011, 4'b0000};
    for (int c = 0; c < 3; c++) begin
      step(); set_idle();
      cif.commit_instr_i[0] = ent(FU_STORE, OP_ADD, 5'd0, 64'h0);
      cif.commit_instr_i[1] = ent(FU_STORE, OP_ADD, 5'd0, 64'h0);
      cif.commit_instr_i[2] = ent(FU_ALU, OP_ADD, 5'd9, 64'h9);
      lsu_credit = (c == 0) ? CW'(1) : (c == 1) ? CW'(2) : CW'(0);
      expect_val($sformatf("store_ack_credit%0d", lsu_credit), 64'(exp_ack[c]));
      expect_val($sformatf("store_lsu_credit%0d", lsu_credit), 64'(exp_lsu[c]));
      @(negedge clk);
      nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
      if (64'(cif.commit_ack_o) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, cif.commit_ack_o, ev); end
      nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
      if (64'(commit_lsu) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, commit_lsu, ev); end
    end
  endtask

  task automatic test_fence();
    logic [15:0] ack_hist;
    logic [3:0]  fence_hist;
    step(); set_idle();
    cif.commit_instr_i[0] = ent(FU_CSR, OP_FENCE, 5'd0, 64'h0);
    cif.commit_instr_i[1] = ent(FU_ALU, OP_ADD, 5'd3, 64'h3);
    expect_val("fence_ack_hist", 64'h1000); expect_val("fence_pulse_hist", 64'h8);
    expect_val("fence_after_ack", 64'h3); expect_val("fence_after_pulse", 64'h0);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) step();
      no_st_pending = (c == 3);
      @(negedge clk);
      ack_hist[c*4 +: 4] = cif.commit_ack_o;
      fence_hist[c] = fence;
    end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(ack_hist) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, ack_hist, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(fence_hist) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, fence_hist, ev); end
    step(); set_idle();
    cif.commit_instr_i[0] = ent(FU_ALU, OP_ADD, 5'd2, 64'h2);
    cif.commit_instr_i[1] = ent(FU_ALU, OP_ADD, 5'd3, 64'h3);
    @(negedge clk);
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(cif.commit_ack_o) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, cif.commit_ack_o, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(fence) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, fence, ev); end
  endtask

  task automatic test_amo();
    int n_valid, n_ack, n_flush, n_we;
    logic [63:0] amo_wdata;
    n_valid = 0; n_ack = 0; n_flush = 0; n_we = 0; amo_wdata = '0;
    step(); set_idle();
    cif.commit_instr_i[0] = ent(FU_STORE, OP_AMO_ADD, 5'd7, 64'h0);
    amo_resp.result = 64'hdead_beef;
    expect_val("amo_valid_cycles", 64'd6); expect_val("amo_ack_count", 64'd1);
    expect_val("amo_flush_count", 64'd1); expect_val("amo_we_count", 64'd1);
    expect_val("amo_wdata", 64'hdead_beef);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) step();
      if (c == 2) halt = 1'b1;
      amo_resp.ack = (c == 5);
      if (c == 6) cif.commit_instr_i = '0;
      @(negedge clk);
      n_valid += int'(amo_valid);
      n_ack   += int'(cif.commit_ack_o[0]);
      n_flush += int'(flush_commit);
      n_we    += int'(cif.we_gpr_o[0]);
      if (cif.commit_ack_o[0]) amo_wdata = cif.wdata_o[0];
    end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(n_valid) !== ev) begin errors++; $display("FAIL %s: got %0d expected %0d", nm, n_valid, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(n_ack) !== ev) begin errors++; $display("FAIL %s: got %0d expected %0d", nm, n_ack, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(n_flush) !== ev) begin errors++; $display("FAIL %s: got %0d expected %0d", nm, n_flush, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(n_we) !== ev) begin errors++; $display("FAIL %s: got %0d expected %0d", nm, n_we, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (amo_wdata !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, amo_wdata, ev); end
  endtask

  task automatic test_fflags();
    step(); set_idle();
    cif.commit_instr_i[0] = ent(FU_FPU, OP_FADD, 5'd1, 64'h11);
    cif.commit_instr_i[1] = ent(FU_FPU, OP_FADD, 5'd2, 64'h22);
    cif.commit_instr_i[0].rd_fpr = 1'b1; cif.commit_instr_i[0].ex.cause = 64'h01;
    cif.commit_instr_i[1].rd_fpr = 1'b1; cif.commit_instr_i[1].ex.cause = 64'h04;
    expect_val("ff_ack", 64'h3); expect_val("ff_write", 64'h1); expect_val("ff_wdata", 64'h5);
    expect_val("ff_dirty", 64'h1); expect_val("ff_we_fpr", 64'h3); expect_val("ff_we_gpr", 64'h0);
    @(negedge clk);
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(cif.commit_ack_o) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, cif.commit_ack_o, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(fflags_we) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, fflags_we, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (csr_wdata !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, csr_wdata, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(dirty_fp) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, dirty_fp, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(cif.we_fpr_o) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, cif.we_fpr_o, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(cif.we_gpr_o) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, cif.we_gpr_o, ev); end
  endtask

  task automatic test_csr();
    step(); set_idle();
    cif.commit_instr_i[0] = ent(FU_CSR, OP_CSRRW, 5'd5, 64'h55);
    cif.commit_instr_i[1] = ent(FU_ALU, OP_ADD, 5'd6, 64'h66);
    cif.commit_instr_i[0].ex.tval = 64'h1234;
    csr_rdata = 64'hc0ffee;
    expect_val("csr_ack", 64'h1); expect_val("csr_commit", 64'h1); expect_val("csr_wdata0", 64'hc0ffee);
    expect_val("csr_op", 64'(OP_CSRRW)); expect_val("csr_wdata_out", 64'h55);
    @(negedge clk);
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(cif.commit_ack_o) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, cif.commit_ack_o, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(commit_csr) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, commit_csr, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (cif.wdata_o[0] !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, cif.wdata_o[0], ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(csr_op) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, csr_op, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (csr_wdata !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, csr_wdata, ev); end

    step();
    csr_exc.valid = 1'b1; csr_exc.cause = 64'h2; csr_exc.tval = 64'hffff;
    expect_val("csrex_ack", 64'h0); expect_val("csrex_valid", 64'h1);
    expect_val("csrex_tval", 64'h1234); expect_val("csrex_cause", 64'h2); expect_val("csrex_we", 64'h0);
    @(negedge clk);
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(cif.commit_ack_o) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, cif.commit_ack_o, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(exc.valid) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, exc.valid, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (exc.tval !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, exc.tval, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (exc.cause !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, exc.cause, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(cif.we_gpr_o) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, cif.we_gpr_o, ev); end

    step();
    cif.commit_instr_i[0].ex.valid = 1'b1; cif.commit_instr_i[0].ex.cause = 64'hd;
    expect_val("headex_cause", 64'hd); expect_val("headex_ack", 64'h0);
    @(negedge clk);
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (exc.cause !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, exc.cause, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(cif.commit_ack_o) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, cif.commit_ack_o, ev); end
  endtask

  task automatic test_single_step();
    step(); set_idle();
    cif.commit_instr_i[0] = ent(FU_ALU, OP_ADD, 5'd1, 64'h1);
    cif.commit_instr_i[1] = ent(FU_ALU, OP_ADD, 5'd2, 64'h2);
    single_step = 1'b1;
    expect_val("sstep_ack", 64'h1);
    @(negedge clk);
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(cif.commit_ack_o) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, cif.commit_ack_o, ev); end
    step(); single_step = 1'b0; halt = 1'b1;
    expect_val("halt_ack", 64'h0);
    @(negedge clk);
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(cif.commit_ack_o) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, cif.commit_ack_o, ev); end
  endtask

  task automatic test_stall_reset();
    logic [4:0] stall_hist;
    step(); set_idle();
    step();
    cif.commit_instr_i[0] = ent(FU_CSR, OP_CSRRS, 5'd4, 64'h0);
    csr_exc.valid = 1'b1; csr_exc.cause = 64'h2; halt = 1'b1;
    expect_val("stall_hist", 64'h10); expect_val("stall_halt_exc", 64'h0);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      @(negedge clk);
      stall_hist[c] = stall;
    end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(stall_hist) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, stall_hist, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(exc.valid) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, exc.valid, ev); end

    // Park the FSM in AMO wait, then pull reset between clock edges
    step(); halt = 1'b0; csr_exc = '0;
    cif.commit_instr_i[0] = ent(FU_STORE, OP_AMO_SWAP, 5'd8, 64'h0);
    step(); halt = 1'b1;
    expect_val("mid_amo_valid", 64'h1); expect_val("mid_stall", 64'h1);
    expect_val("rst_amo_valid", 64'h0); expect_val("rst_stall_clear", 64'h0);
    @(negedge clk);
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(amo_valid) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, amo_valid, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(stall) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, stall, ev); end
    #2 rst_n = 1'b0;
    #1;
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(amo_valid) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, amo_valid, ev); end
    nm = name_q.pop_front(); ev = val_q.pop_front(); checks++;
    if (64'(stall) !== ev) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, stall, ev); end
    step(); rst_n = 1'b1; set_idle();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu4();
    test_store_credit();
    test_fence();
    test_amo();
    test_fflags();
    test_csr();
    test_single_step();
    test_stall_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
